// File: rtl/toep_mvmul_seq.sv
// Sequential Toeplitz matrix-vector multiplier: one matrix column per cycle
// across N signed MAC lanes, with valid/ready on both sides.
module toep_mac_lane #(
  parameter int UNIT_SIZE = 8,
  parameter int ACC_W     = 18
) (
  input  logic                        i_clk,
  input  logic                        i_rstn,
  input  logic                        i_clr,
  input  logic                        i_en,
  input  logic signed [UNIT_SIZE-1:0] i_a,
  input  logic signed [UNIT_SIZE-1:0] i_b,
  output logic signed [ACC_W-1:0]     o_acc_d
);
  logic signed [2*UNIT_SIZE-1:0] prod;
  logic signed [ACC_W-1:0]       acc;

  assign prod    = i_a * i_b;
  // o_acc_d is the next accumulator value so the top can capture the final sum
  // on the same edge that retires the last column.
  assign o_acc_d = i_en ? acc + ACC_W'(prod) : acc;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn)    acc <= '0;
    else if (i_clr) acc <= '0;
    else if (i_en)  acc <= o_acc_d;
  end
endmodule

module toep_mvmul_seq #(
  parameter int N         = 4,
  parameter int UNIT_SIZE = 8,
  parameter int ACC_W     = 2*UNIT_SIZE + $clog2(N)
) (
  input  logic                           i_clk,
  input  logic                           i_rstn,
  input  logic                           i_en,
  input  logic                           i_valid,
  output logic                           o_ready,
  input  logic [$clog2(N+1)-1:0]         i_dim,
  input  logic [(2*N-1)*UNIT_SIZE-1:0]   i_mat,
  input  logic [N*UNIT_SIZE-1:0]         i_vec,
  output logic                           o_valid,
  input  logic                           i_ready,
  output logic [N*ACC_W-1:0]             o_data,
  output logic                           o_busy
);
  localparam int KW = $clog2(N+1);
  localparam int IW = $clog2(2*N);
  localparam int TD = 1 << IW;
  localparam int VD = 1 << KW;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                      state;
  logic [KW-1:0]               k_q, col, k_in;
  // Operand stores are padded to power-of-two depth so every index value is in range.
  logic signed [UNIT_SIZE-1:0] t_q [TD];
  logic signed [UNIT_SIZE-1:0] v_q [VD];
  logic signed [ACC_W-1:0]     acc_d [N];
  logic                        accept, step, last;

  assign o_ready = (state == IDLE);
  assign o_busy  = (state != IDLE);
  assign accept  = i_valid && o_ready && i_en;
  assign step    = (state == CALC) && i_en;
  assign last    = step && (col == k_q - KW'(1));
  assign k_in    = (i_dim == '0 || i_dim > KW'(N)) ? KW'(N) : i_dim;

  for (genvar r = 0; r < N; r++) begin : g_lane
    logic [IW-1:0] idx;
    // M[r][col] = t[K-1-r+col]; lanes at or beyond K stay idle and hold zero.
    assign idx = IW'(k_q) + IW'(col) - IW'(r + 1);
    toep_mac_lane #(.UNIT_SIZE(UNIT_SIZE), .ACC_W(ACC_W)) u_lane (
      .i_clk   (i_clk),
      .i_rstn  (i_rstn),
      .i_clr   (accept),
      .i_en    (step && (KW'(r) < k_q)),
      .i_a     (t_q[idx]),
      .i_b     (v_q[col]),
      .o_acc_d (acc_d[r])
    );
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state   <= IDLE;
      k_q     <= '0;
      col     <= '0;
      o_valid <= 1'b0;
      o_data  <= '0;
      for (int i = 0; i < TD; i++) t_q[i] <= '0;
      for (int i = 0; i < VD; i++) v_q[i] <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          k_q   <= k_in;
          col   <= '0;
          for (int k = 0; k < 2*N-1; k++) t_q[k] <= i_mat[k*UNIT_SIZE +: UNIT_SIZE];
          for (int j = 0; j < N; j++)     v_q[j] <= i_vec[j*UNIT_SIZE +: UNIT_SIZE];
          state <= CALC;
        end
        CALC: if (step) begin
          col <= col + KW'(1);
          if (last) begin
            for (int r = 0; r < N; r++) o_data[r*ACC_W +: ACC_W] <= acc_d[r];
            o_valid <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: if (i_ready) begin
          o_valid <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_toep_mvmul_seq.sv
// Randomized and directed bench for toep_mvmul_seq against a plain
// matrix-vector reference model.
module tb_toep_mvmul_seq;
  localparam int N  = 4;
  localparam int UW = 8;
  localparam int AW = 2*UW + $clog2(N);
  localparam int KW = $clog2(N+1);

  typedef logic [(2*N-1)*UW-1:0] mat_t;
  typedef logic [N*UW-1:0]       vec_t;
  typedef logic [N*AW-1:0]       res_t;

  logic          i_clk, i_rstn, i_en, i_valid, o_ready, o_valid, i_ready, o_busy;
  logic [KW-1:0] i_dim;
  mat_t          i_mat;
  vec_t          i_vec;
  res_t          o_data;

  int   n_tests, n_fail, cyc;
  int   acc_q[$], xfer_q[$];
  res_t data_q[$];

  toep_mvmul_seq #(.N(N), .UNIT_SIZE(UW)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_en(i_en), .i_valid(i_valid),
    .o_ready(o_ready), .i_dim(i_dim), .i_mat(i_mat), .i_vec(i_vec),
    .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_busy(o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Handshake monitor: records cycle numbers of accepts and transfers.
  always @(posedge i_clk) begin
    cyc <= cyc + 1;
    if (i_rstn && i_valid && o_ready && i_en) acc_q.push_back(cyc);
    if (i_rstn && o_valid && i_ready) begin
      xfer_q.push_back(cyc);
      data_q.push_back(o_data);
    end
  end

  function automatic res_t model(input mat_t m, input vec_t v, input int dim);
    int     k;
    longint s;
    res_t   y;
    k = (dim == 0 || dim > N) ? N : dim;
    y = '0;
    for (int r = 0; r < k; r++) begin
      s = 0;
      for (int c = 0; c < k; c++)
        s += longint'($signed(m[(k-1-r+c)*UW +: UW])) * longint'($signed(v[c*UW +: UW]));
      y[r*AW +: AW] = AW'(s);
    end
    return y;
  endfunction

  function automatic res_t pack_res(input int y0, input int y1, input int y2, input int y3);
    res_t y;
    y = '0;
    y[0*AW +: AW] = AW'(y0);
    y[1*AW +: AW] = AW'(y1);
    y[2*AW +: AW] = AW'(y2);
    y[3*AW +: AW] = AW'(y3);
    return y;
  endfunction

  task automatic send(input mat_t m, input vec_t v, input int dim, output bit ok);
    int n0;
    @(negedge i_clk);
    i_mat = m; i_vec = v; i_dim = KW'(dim); i_valid = 1'b1;
    n0 = acc_q.size(); ok = 1'b0;
    for (int i = 0; i < 40; i++)
      if (!ok) begin
        @(negedge i_clk);
        if (acc_q.size() > n0) ok = 1'b1;
      end
    i_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat, output bit ok);
    int n;
    ok = 1'b0; lat = -1; n = 0;
    while (!ok && n < 60) begin
      if (o_valid) begin
        ok  = 1'b1;
        lat = cyc - 1 - acc_q[$];
      end else begin
        @(negedge i_clk);
        n++;
      end
    end
  endtask

  task automatic take(output res_t d);
    d = o_data;
    i_ready = 1'b1;
    @(negedge i_clk);
    i_ready = 1'b0;
  endtask

  task automatic test_reset;
    n_tests++; if (o_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_valid: got %b want 0", o_valid); end
    n_tests++; if (o_data !== '0)     begin n_fail++; $display("FAIL reset_data: got %h want 0", o_data); end
    n_tests++; if (o_ready !== 1'b1)  begin n_fail++; $display("FAIL reset_ready: got %b want 1", o_ready); end
    n_tests++; if (o_busy !== 1'b0)   begin n_fail++; $display("FAIL reset_busy: got %b want 0", o_busy); end
  endtask

  task automatic test_k3;
    mat_t m; vec_t v; res_t d; int lat; bit ok;
    for (int k = 0; k < 2*N-1; k++) m[k*UW +: UW] = UW'(k + 1);
    v = {8'sd7, 8'sd1, 8'sd1, 8'sd1};
    send(m, v, 3, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL k3_accept: not accepted within bound"); end
    n_tests++; if (o_busy !== 1'b1 || o_ready !== 1'b0) begin n_fail++; $display("FAIL k3_busy: busy %b ready %b want 1 0", o_busy, o_ready); end
    wait_valid(lat, ok);
    n_tests++; if (!ok || lat != 3) begin n_fail++; $display("FAIL k3_latency: got %0d want 3", lat); end
    take(d);
    n_tests++; if (d !== pack_res(12, 9, 6, 0)) begin n_fail++; $display("FAIL k3_data: got %h want %h", d, pack_res(12, 9, 6, 0)); end
    n_tests++; if (o_valid !== 1'b0 || o_ready !== 1'b1) begin n_fail++; $display("FAIL k3_release: valid %b ready %b want 0 1", o_valid, o_ready); end
    n_tests++; if (o_data !== d) begin n_fail++; $display("FAIL k3_hold_idle: got %h want %h", o_data, d); end
  endtask

  task automatic test_k2;
    mat_t m; vec_t v; res_t d; int lat; bit ok;
    for (int k = 0; k < 2*N-1; k++) m[k*UW +: UW] = UW'($urandom);
    for (int j = 0; j < N; j++)     v[j*UW +: UW] = UW'($urandom);
    m[0 +: 3*UW] = {8'sd3, 8'sd2, 8'sd1};
    v[0 +: 2*UW] = {8'sd1, 8'sd2};
    send(m, v, 2, ok);
    wait_valid(lat, ok);
    n_tests++; if (!ok || lat != 2) begin n_fail++; $display("FAIL k2_latency: got %0d want 2", lat); end
    take(d);
    n_tests++; if (d !== pack_res(7, 4, 0, 0)) begin n_fail++; $display("FAIL k2_data: got %h want %h", d, pack_res(7, 4, 0, 0)); end
  endtask

  task automatic test_signed_extreme;
    mat_t m; vec_t v; res_t d; int lat; bit ok;
    for (int k = 0; k < 2*N-1; k++) m[k*UW +: UW] = 8'h80;
    for (int j = 0; j < N; j++)     v[j*UW +: UW] = 8'h80;
    for (int pass = 0; pass < 2; pass++) begin
      send(m, v, pass == 0 ? 4 : 0, ok);
      wait_valid(lat, ok);
      n_tests++; if (!ok || lat != 4) begin n_fail++; $display("FAIL extreme_latency[%0d]: got %0d want 4", pass, lat); end
      take(d);
      n_tests++; if (d !== pack_res(65536, 65536, 65536, 65536)) begin n_fail++; $display("FAIL extreme_data[%0d]: got %h want %h", pass, d, pack_res(65536, 65536, 65536, 65536)); end
    end
  endtask

  task automatic test_stall_pulse;
    mat_t m, m2; vec_t v; res_t d; int lat, n0; bit ok;
    for (int k = 0; k < 2*N-1; k++) m[k*UW +: UW] = UW'(k + 1);
    for (int k = 0; k < 2*N-1; k++) m2[k*UW +: UW] = UW'($urandom);
    v = {8'sd0, 8'sd1, 8'sd1, 8'sd1};
    send(m, v, 3, ok);
    n0 = acc_q.size();
    // stray operand set while busy, with different contents
    i_valid = 1'b1; i_mat = m2; i_dim = 3'd4;
    @(negedge i_clk);
    i_valid = 1'b0; i_en = 1'b0;
    repeat (3) @(negedge i_clk);
    i_en = 1'b1;
    wait_valid(lat, ok);
    n_tests++; if (!ok || lat != 6) begin n_fail++; $display("FAIL stall_latency: got %0d want 6", lat); end
    take(d);
    n_tests++; if (d !== pack_res(12, 9, 6, 0)) begin n_fail++; $display("FAIL stall_data: got %h want %h", d, pack_res(12, 9, 6, 0)); end
    repeat (3) @(negedge i_clk);
    n_tests++; if (acc_q.size() != n0 || o_valid !== 1'b0) begin n_fail++; $display("FAIL stray_valid: accepts %0d valid %b want %0d 0", acc_q.size(), o_valid, n0); end
  endtask

  task automatic test_backpressure;
    mat_t m; vec_t v; res_t d0, d; int lat; bit ok;
    for (int k = 0; k < 2*N-1; k++) m[k*UW +: UW] = UW'($urandom);
    for (int j = 0; j < N; j++)     v[j*UW +: UW] = UW'($urandom);
    send(m, v, 4, ok);
    wait_valid(lat, ok);
    d0 = o_data;
    n_tests++; if (!ok || d0 !== model(m, v, 4)) begin n_fail++; $display("FAIL bp_data: got %h want %h", d0, model(m, v, 4)); end
    for (int i = 0; i < 5; i++) begin
      @(negedge i_clk);
      n_tests++;
      if (o_valid !== 1'b1 || o_data !== d0 || o_ready !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold[%0d]: valid %b ready %b data %h want 1 0 %h", i, o_valid, o_ready, o_data, d0);
      end
    end
    take(d);
    n_tests++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release: got %b want 0", o_valid); end
  endtask

  task automatic test_reset_mid;
    mat_t m; vec_t v; res_t d; int lat; bit ok;
    for (int k = 0; k < 2*N-1; k++) m[k*UW +: UW] = UW'($urandom);
    for (int j = 0; j < N; j++)     v[j*UW +: UW] = UW'($urandom);
    send(m, v, 4, ok);
    @(posedge i_clk);
    #3 i_rstn = 1'b0;
    #1;
    n_tests++;
    if (o_valid !== 1'b0 || o_data !== '0 || o_ready !== 1'b1 || o_busy !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid: valid %b data %h ready %b busy %b want 0 0 1 0", o_valid, o_data, o_ready, o_busy);
    end
    @(negedge i_clk);
    i_rstn = 1'b1;
    for (int k = 0; k < 2*N-1; k++) m[k*UW +: UW] = UW'($urandom);
    send(m, v, 3, ok);
    wait_valid(lat, ok);
    n_tests++; if (!ok || lat != 3) begin n_fail++; $display("FAIL rst_after_latency: got %0d want 3", lat); end
    take(d);
    n_tests++; if (d !== model(m, v, 3)) begin n_fail++; $display("FAIL rst_after_data: got %h want %h", d, model(m, v, 3)); end
  endtask

  task automatic test_back_to_back;
    mat_t ma, mb; vec_t va, vb; int ka, kb, n;
    ka = $urandom_range(1, N); kb = $urandom_range(1, N);
    for (int k = 0; k < 2*N-1; k++) begin ma[k*UW +: UW] = UW'($urandom); mb[k*UW +: UW] = UW'($urandom); end
    for (int j = 0; j < N; j++)     begin va[j*UW +: UW] = UW'($urandom); vb[j*UW +: UW] = UW'($urandom); end
    acc_q.delete(); xfer_q.delete(); data_q.delete();
    @(negedge i_clk);
    i_mat = ma; i_vec = va; i_dim = KW'(ka); i_valid = 1'b1; i_ready = 1'b1;
    n = 0;
    while (acc_q.size() < 1 && n < 40) begin @(negedge i_clk); n++; end
    i_mat = mb; i_vec = vb; i_dim = KW'(kb);
    while (acc_q.size() < 2 && n < 80) begin @(negedge i_clk); n++; end
    i_valid = 1'b0;
    while (xfer_q.size() < 2 && n < 120) begin @(negedge i_clk); n++; end
    i_ready = 1'b0;
    n_tests++;
    if (acc_q.size() != 2 || xfer_q.size() != 2) begin
      n_fail++; $display("FAIL b2b_count: accepts %0d transfers %0d want 2 2", acc_q.size(), xfer_q.size());
    end else begin
      n_tests++; if (data_q[0] !== model(ma, va, ka)) begin n_fail++; $display("FAIL b2b_data_a: got %h want %h", data_q[0], model(ma, va, ka)); end
      n_tests++; if (data_q[1] !== model(mb, vb, kb)) begin n_fail++; $display("FAIL b2b_data_b: got %h want %h", data_q[1], model(mb, vb, kb)); end
      n_tests++; if (xfer_q[0] - acc_q[0] != ka + 1) begin n_fail++; $display("FAIL b2b_first_span: got %0d want %0d", xfer_q[0] - acc_q[0], ka + 1); end
      n_tests++; if (acc_q[1] != xfer_q[0] + 1) begin n_fail++; $display("FAIL b2b_second_accept: got %0d want %0d", acc_q[1], xfer_q[0] + 1); end
    end
  endtask

  task automatic test_random;
    mat_t m; vec_t v; res_t d; int dim, kexp, lat; bit ok;
    for (int it = 0; it < 20; it++) begin
      for (int k = 0; k < 2*N-1; k++) m[k*UW +: UW] = UW'($urandom);
      for (int j = 0; j < N; j++)     v[j*UW +: UW] = UW'($urandom);
      dim  = $urandom_range(0, 7);
      kexp = (dim == 0 || dim > N) ? N : dim;
      send(m, v, dim, ok);
      wait_valid(lat, ok);
      n_tests++; if (!ok || lat != kexp) begin n_fail++; $display("FAIL rand_latency[%0d]: dim %0d got %0d want %0d", it, dim, lat, kexp); end
      repeat ($urandom_range(0, 3)) @(negedge i_clk);
      take(d);
      n_tests++; if (d !== model(m, v, dim)) begin n_fail++; $display("FAIL rand_data[%0d]: dim %0d got %h want %h", it, dim, d, model(m, v, dim)); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests + 1, n_fail + 1);
    $fatal(1);
  end

  initial begin
    n_tests = 0; n_fail = 0; cyc = 0;
    i_rstn = 1'b0; i_en = 1'b1; i_valid = 1'b0; i_ready = 1'b0;
    i_dim = '0; i_mat = '0; i_vec = '0;
    repeat (2) @(negedge i_clk);
    test_reset;
    i_rstn = 1'b1;
    test_k3;
    test_k2;
    test_signed_extreme;
    test_stall_pulse;
    test_backpressure;
    test_reset_mid;
    test_back_to_back;
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
